// File: rtl/switch_debounce4.sv
// Slide-switch conditioner: two-flop synchronizer plus a per-bit debounce counter
// feeding a registered 4-bit value, a change strobe and a settled flag.
module switch_debounce4 #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw_in,
  output logic [3:0] numero,
  output logic       changed,
  output logic       stable
);

  localparam int unsigned N_BITS = 4;
  localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_BITS-1:0] sync1_q, sync2_q;
  logic [N_BITS-1:0] numero_q, numero_d;
  logic              changed_q, changed_d;
  logic [CNT_W-1:0]  cnt_q [N_BITS];
  logic [CNT_W-1:0]  cnt_d [N_BITS];
  logic              cnt_idle_c;

  // A bit flips only after its synchronized level has disagreed for DEBOUNCE_CYCLES edges.
  always_comb begin
    numero_d = numero_q;
    for (int i = 0; i < N_BITS; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != numero_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          numero_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
    changed_d = |(numero_d ^ numero_q);
  end

  always_comb begin
    cnt_idle_c = 1'b1;
    for (int i = 0; i < N_BITS; i++) begin
      if (cnt_q[i] != '0) begin
        cnt_idle_c = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      numero_q  <= '0;
      changed_q <= 1'b0;
      for (int i = 0; i < N_BITS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q   <= sw_in;
      sync2_q   <= sync1_q;
      numero_q  <= numero_d;
      changed_q <= changed_d;
      for (int i = 0; i < N_BITS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign numero  = numero_q;
  assign changed = changed_q;
  assign stable  = (sync2_q == numero_q) && cnt_idle_c;

endmodule
